// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the commit trace buffer: record layout and serializer states.
package commit_trace_buffer_pkg;

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      reg_addr;
        logic [XLEN-1:0] reg_data;
    } trace_rec_t;

    typedef enum logic [2:0] {
        StIdle,
        StPc,
        StInstr,
        StRd,
        StData
    } trace_state_e;

endpackage

// File: rtl/commit_trace_buffer_trace_fifo.sv
// Circular record store with a combinational head read and an occupancy count.
module trace_fifo
    import commit_trace_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  trace_rec_t               wdata_i,
    output trace_rec_t               head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    trace_rec_t    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;

    always_comb begin
        level_d = level_q;
        if (push_i && !pop_i) begin
            level_d = level_q + 1'b1;
        end else if (!push_i && pop_i) begin
            level_d = level_q - 1'b1;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_i) begin
                rptr_q <= rptr_q + 1'b1;
            end
            level_q <= level_d;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Buffers commit trace records and drains them as a word-serial valid/ready stream.
module commit_trace_buffer
    import commit_trace_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DROP_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     update_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [XLEN-1:0]          instr_i,
    input  logic [4:0]               reg_addr_i,
    input  logic [XLEN-1:0]          reg_data_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [XLEN-1:0]          m_data_o,
    output logic                     m_last_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [DROP_W-1:0]        drop_cnt_o
);

    trace_state_e      state_q;
    logic              valid_q;
    logic [DROP_W-1:0] drop_q;
    trace_rec_t        head;
    trace_rec_t        wrec;
    logic              full;
    logic              empty;
    logic              hs;
    logic              last_word;
    logic              pop;
    logic              push;
    logic              more_after_pop;

    assign wrec = '{pc: pc_i, instr: instr_i, reg_addr: reg_addr_i, reg_data: reg_data_i};

    assign hs        = valid_q && m_ready_i;
    assign last_word = (state_q == StData) || (state_q == StRd && head.reg_addr == 5'd0);
    assign pop       = hs && last_word;
    // A full buffer still accepts a record when the head leaves on the same edge.
    assign push      = update_i && (!full || pop);
    // A pop implies level >= 1, so the post-edge level is nonzero unless it was exactly 1.
    assign more_after_pop = push || (level_o != ($clog2(DEPTH)+1)'(1));

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wrec),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        state_q <= StPc;
                        valid_q <= 1'b1;
                    end
                end
                StPc: begin
                    if (hs) state_q <= StInstr;
                end
                StInstr: begin
                    if (hs) state_q <= StRd;
                end
                StRd, StData: begin
                    if (hs) begin
                        if (!last_word) begin
                            state_q <= StData;
                        end else if (more_after_pop) begin
                            state_q <= StPc;
                        end else begin
                            state_q <= StIdle;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            drop_q <= '0;
        end else if (update_i && !push && drop_q != '1) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    always_comb begin
        m_data_o = '0;
        unique case (state_q)
            StPc:    m_data_o = head.pc;
            StInstr: m_data_o = head.instr;
            StRd:    m_data_o = XLEN'(head.reg_addr);
            StData:  m_data_o = head.reg_data;
            default: m_data_o = '0;
        endcase
    end

    assign m_valid_o  = valid_q;
    assign m_last_o   = valid_q && last_word;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized bench comparing the trace buffer against a queue-based stream model.
module tb_commit_trace_buffer;
    import commit_trace_buffer_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DROP_W = 16;

    logic            clk_i = 1'b0;
    logic            rstn_i = 1'b0;
    logic            update_i = 1'b0;
    logic [XLEN-1:0] pc_i = '0;
    logic [XLEN-1:0] instr_i = '0;
    logic [4:0]      reg_addr_i = '0;
    logic [XLEN-1:0] reg_data_i = '0;
    logic            m_valid_o;
    logic            m_ready_i = 1'b0;
    logic [XLEN-1:0] m_data_o;
    logic            m_last_o;
    logic [4:0]      level_o;
    logic [DROP_W-1:0] drop_cnt_o;

    always #5 clk_i = ~clk_i;

    commit_trace_buffer #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .update_i   (update_i),
        .pc_i       (pc_i),
        .instr_i    (instr_i),
        .reg_addr_i (reg_addr_i),
        .reg_data_i (reg_data_i),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .m_data_o   (m_data_o),
        .m_last_o   (m_last_o),
        .level_o    (level_o),
        .drop_cnt_o (drop_cnt_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a queue of stored records plus the index of the word being offered (-1 = none).
    trace_rec_t mq[$];
    int         widx  = -1;
    int         mdrop = 0;

    logic            prev_stall = 1'b0;
    logic [XLEN-1:0] prev_data  = '0;
    logic            prev_last  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nwords(trace_rec_t r);
        return (r.reg_addr == 5'd0) ? 3 : 4;
    endfunction

    function automatic logic [XLEN-1:0] word_of(trace_rec_t r, int i);
        case (i)
            0:       return r.pc;
            1:       return r.instr;
            2:       return XLEN'(r.reg_addr);
            default: return r.reg_data;
        endcase
    endfunction

    function automatic logic m_valid();
        return widx >= 0;
    endfunction

    function automatic logic [XLEN-1:0] m_data();
        return (widx >= 0) ? word_of(mq[0], widx) : '0;
    endfunction

    function automatic logic m_last();
        return (widx >= 0) && (widx == nwords(mq[0]) - 1);
    endfunction

    function automatic trace_rec_t rand_rec();
        trace_rec_t r;
        r.pc       = $urandom;
        r.instr    = $urandom;
        r.reg_addr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        r.reg_data = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        widx  = -1;
        mdrop = 0;
        prev_stall = 1'b0;
    endtask

    task automatic model_step(input logic upd, input trace_rec_t r, input logic rdy);
        int pre;
        logic hs, pop, acc;
        pre = mq.size();
        hs  = m_valid() && rdy;
        pop = hs && m_last();
        acc = upd && (pre < DEPTH || pop);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(r);
        else if (upd && mdrop < (1 << DROP_W) - 1) mdrop++;
        if (widx < 0) widx = (pre != 0) ? 0 : -1;
        else if (pop) widx = (mq.size() != 0) ? 0 : -1;
        else if (hs) widx++;
    endtask

    task automatic compare_outputs();
        if (prev_stall) begin
            check("stall_data", 64'(m_data_o), 64'(prev_data));
            check("stall_last", 64'(m_last_o), 64'(prev_last));
        end
        check("valid", 64'(m_valid_o), 64'(m_valid()));
        check("data", 64'(m_data_o), 64'(m_data()));
        check("last", 64'(m_last_o), 64'(m_last()));
        check("level", 64'(level_o), 64'(mq.size()));
        check("drop", 64'(drop_cnt_o), 64'(mdrop));
    endtask

    task automatic cycle(input logic upd, input trace_rec_t r, input logic rdy);
        @(negedge clk_i);
        compare_outputs();
        prev_stall = m_valid_o && !rdy;
        prev_data  = m_data_o;
        prev_last  = m_last_o;
        update_i   = upd;
        pc_i       = r.pc;
        instr_i    = r.instr;
        reg_addr_i = r.reg_addr;
        reg_data_i = r.reg_data;
        m_ready_i  = rdy;
        @(posedge clk_i);
        model_step(upd, r, rdy);
    endtask

    trace_rec_t rec;
    trace_rec_t nil;
    int         drop_before;

    initial begin
        nil = '0;
        model_reset();
        #12 rstn_i = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, nil, 1'b1);

        // Single commit with a register write: four words.
        rec = '{pc: 32'h8000_0000, instr: 32'h0050_0293, reg_addr: 5'd5, reg_data: 32'h5};
        cycle(1'b1, rec, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, nil, 1'b1);

        // Commit without a register write: three words.
        rec = '{pc: 32'h8000_0004, instr: 32'h0000_0013, reg_addr: 5'd0, reg_data: 32'hdead_beef};
        cycle(1'b1, rec, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, nil, 1'b1);

        // Overfill while stalled, then drain.
        for (int i = 0; i < DEPTH + 3; i++) cycle(1'b1, rand_rec(), 1'b0);
        #1;
        check("fill_level", 64'(level_o), 64'(16));
        check("fill_drop", 64'(drop_cnt_o), 64'(3));
        for (int i = 0; i < DEPTH * 4 + 6; i++) cycle(1'b0, nil, 1'b1);

        // Full buffer: push on the same edge as the head's last word.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, rand_rec(), 1'b0);
        drop_before = mdrop;
        for (int i = 0; i < 8 && !m_last(); i++) cycle(1'b0, nil, 1'b1);
        rec = rand_rec();
        cycle(1'b1, rec, 1'b1);
        #1;
        check("swap_level", 64'(level_o), 64'(16));
        check("swap_drop", 64'(drop_cnt_o), 64'(drop_before));
        check("swap_tail", 64'(mq[mq.size()-1].pc), 64'(rec.pc));
        for (int i = 0; i < DEPTH * 4 + 6; i++) cycle(1'b0, nil, 1'b1);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 2) == 0), rand_rec(), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 300; i++) cycle(($urandom_range(0, 5) == 0), rand_rec(), $urandom_range(0, 1) == 1);
        for (int i = 0; i < DEPTH * 4 + 6; i++) cycle(1'b0, nil, 1'b1);

        // Reset while the INSTR word is on the bus.
        cycle(1'b1, rand_rec(), 1'b1);
        for (int i = 0; i < 6 && widx != 1; i++) cycle(1'b0, nil, 1'b1);
        @(negedge clk_i);
        check("pre_rst_instr", 64'(widx), 64'(1));
        update_i = 1'b0;
        rstn_i   = 1'b0;
        #1;
        check("rst_valid", 64'(m_valid_o), 64'(0));
        check("rst_data", 64'(m_data_o), 64'(0));
        check("rst_last", 64'(m_last_o), 64'(0));
        check("rst_level", 64'(level_o), 64'(0));
        check("rst_drop", 64'(drop_cnt_o), 64'(0));
        model_reset();
        @(negedge clk_i);
        rstn_i = 1'b1;
        for (int i = 0; i < 10; i++) cycle(1'b0, nil, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
